// File: rtl/fft_capture.sv
// fft_capture: packs a streaming FFT frame into the channel-1 FFT RAM and
// holds the stored frame until the peak-bin detector has read it back.
module fft_capture #(
    parameter int NPOINTS = 2048,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sink_valid,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [DATA_W-1:0]     sink_real,
    input  logic [DATA_W-1:0]     sink_imag,
    output logic                  sink_ready,
    input  logic                  detectdone,
    output logic [ADDR_W-1:0]     ramaddr,
    output logic [2*DATA_W-1:0]   ramdata,
    output logic                  ramwren,
    output logic                  fftdone,
    output logic                  frame_err,
    output logic [7:0]            frame_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPOINTS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                dd_q;
    logic                done_pend;
    logic                take;
    logic                rise;
    logic [2*DATA_W-1:0] beat;

    assign take = sink_valid && sink_ready;
    assign rise = detectdone && !dd_q;
    assign beat = {sink_real, sink_imag};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dd_q        <= 1'b0;
            done_pend   <= 1'b0;
            sink_ready  <= 1'b0;
            ramaddr     <= '0;
            ramdata     <= '0;
            ramwren     <= 1'b0;
            fftdone     <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            dd_q      <= detectdone;
            ramwren   <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    sink_ready <= 1'b1;
                    if (take && sink_sop) begin
                        ramwren <= 1'b1;
                        ramaddr <= '0;
                        ramdata <= beat;
                        cnt     <= ADDR_W'(1);
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (take) begin
                        ramwren <= 1'b1;
                        ramdata <= beat;
                        // A fresh sop always wins: restart at bin 0.
                        if (sink_sop) begin
                            ramaddr   <= '0;
                            cnt       <= ADDR_W'(1);
                            frame_err <= 1'b1;
                        end else begin
                            ramaddr <= cnt;
                            if (cnt == LAST) begin
                                cnt <= '0;
                                if (sink_eop) begin
                                    sink_ready <= 1'b0;
                                    done_pend  <= 1'b1;
                                    state      <= HOLD;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= IDLE;
                                end
                            end else if (sink_eop) begin
                                cnt       <= '0;
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                cnt <= cnt + ADDR_W'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    sink_ready <= 1'b0;
                    // fftdone follows the final write by one cycle.
                    if (done_pend) begin
                        done_pend   <= 1'b0;
                        fftdone     <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end else if (rise) begin
                        fftdone    <= 1'b0;
                        ramaddr    <= '0;
                        sink_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_capture.sv
// Self-checking bench for fft_capture: table of framing scenarios plus
// randomized beat streams checked against a frame-level reference model.
module tb_fft_capture;

    localparam int N  = 2048;
    localparam int AW = 11;
    localparam int DW = 14;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [1:0]    gap;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0]   a;
        logic [2*DW-1:0] d;
    } wr_t;

    typedef struct {
        int len;
        int eop_at;
        int sop2;
        int gap;
        int writes;
        int errs;
        int frames;
        bit hold;
    } vec_t;

    logic            clk;
    logic            reset;
    logic            sink_valid;
    logic            sink_sop;
    logic            sink_eop;
    logic [DW-1:0]   sink_real;
    logic [DW-1:0]   sink_imag;
    logic            sink_ready;
    logic            detectdone;
    logic [AW-1:0]   ramaddr;
    logic [2*DW-1:0] ramdata;
    logic            ramwren;
    logic            fftdone;
    logic            frame_err;
    logic [7:0]      frame_count;

    int    checks = 0;
    int    errors = 0;
    beat_t stim_q[$];
    wr_t   exp_q[$];
    wr_t   got_q[$];
    int    got_err = 0;
    int    exp_err;
    int    exp_frames;
    int    stop_n;
    bit    exp_hold;
    int    exp_fc;
    int    m_pos;
    int    last_wb;
    vec_t  tbl[5];

    fft_capture #(.NPOINTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .sink_ready(sink_ready),
        .detectdone(detectdone), .ramaddr(ramaddr), .ramdata(ramdata),
        .ramwren(ramwren), .fftdone(fftdone), .frame_err(frame_err),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ramwren) got_q.push_back(wr_t'({ramaddr, ramdata}));
        if (frame_err) got_err++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mk_frame(input int len, input int eop_at, input int sop2, input int gap);
        stim_q.delete();
        for (int b = 0; b < len; b++) begin
            beat_t t;
            logic [DW-1:0] k;
            k     = DW'(b);
            t.sop = (b == 0) || (b == sop2);
            t.eop = (b == eop_at);
            t.re  = k;
            t.im  = ~k;
            t.gap = 2'(gap);
            stim_q.push_back(t);
        end
    endtask

    task automatic mk_rand(input int len, input bit full);
        stim_q.delete();
        for (int b = 0; b < len; b++) begin
            beat_t t;
            if (full) begin
                t.sop = (b == 0);
                t.eop = (b == N - 1);
            end else begin
                t.sop = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0);
                t.eop = ($urandom_range(0, 299) == 0);
            end
            t.re  = DW'($urandom);
            t.im  = DW'($urandom);
            t.gap = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            stim_q.push_back(t);
        end
    endtask

    // Frame-level model: m_pos is the next bin index, -1 while waiting for sop.
    task automatic run_model();
        exp_q.delete();
        exp_err    = 0;
        exp_frames = 0;
        exp_hold   = 0;
        stop_n     = stim_q.size();
        for (int i = 0; i < stim_q.size(); i++) begin
            beat_t b;
            b = stim_q[i];
            if (b.sop) begin
                if (m_pos >= 0) exp_err++;
                exp_q.push_back(wr_t'({AW'(0), b.re, b.im}));
                m_pos = 1;
            end else if (m_pos >= 0) begin
                exp_q.push_back(wr_t'({AW'(m_pos), b.re, b.im}));
                if (b.eop && m_pos == N - 1) begin
                    exp_frames++;
                    exp_hold = 1;
                    m_pos    = -1;
                    stop_n   = i + 1;
                    break;
                end else if (b.eop || m_pos == N - 1) begin
                    exp_err++;
                    m_pos = -1;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            for (int g = 0; g < int'(stim_q[i].gap); g++) begin
                @(negedge clk);
                sink_valid = 1'b0;
            end
            @(negedge clk);
            w = 0;
            while (!sink_ready && w < 50) begin
                sink_valid = 1'b0;
                @(negedge clk);
                w++;
            end
            if (!sink_ready) begin
                checks++;
                errors++;
                $display("FAIL ready_wait: got sink_ready=0 for 50 cycles at beat %0d, expected 1", i);
                sink_valid = 1'b0;
                return;
            end
            sink_valid = 1'b1;
            sink_sop   = stim_q[i].sop;
            sink_eop   = stim_q[i].eop;
            sink_real  = stim_q[i].re;
            sink_imag  = stim_q[i].im;
        end
        @(negedge clk);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic cmp_image(input string name, input int wb);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wb + i >= got_q.size()) begin
                bad++;
            end else if (got_q[wb + i] !== exp_q[i]) begin
                if (bad == 0)
                    $display("  %s first bad write %0d: addr %0d data %h, want addr %0d data %h",
                             name, i, got_q[wb + i].a, got_q[wb + i].d, exp_q[i].a, exp_q[i].d);
                bad++;
            end
        end
        chk({name, "_image"}, 64'(bad), 64'(0));
    endtask

    task automatic release_hold(input string name);
        if (detectdone) begin
            repeat (5) @(negedge clk);
            chk({name, "_hold_sticky"}, 64'(fftdone), 64'(1));
            chk({name, "_hold_ready"}, 64'(sink_ready), 64'(0));
            detectdone = 1'b0;
            @(negedge clk);
            chk({name, "_hold_low"}, 64'(fftdone), 64'(1));
        end
        detectdone = 1'b1;
        @(negedge clk);
        chk({name, "_rel_done"}, 64'(fftdone), 64'(0));
        chk({name, "_rel_ready"}, 64'(sink_ready), 64'(1));
        chk({name, "_rel_addr"}, 64'(ramaddr), 64'(0));
    endtask

    task automatic apply(input string name, input int writes, input int errs,
                         input int frames, input bit hold);
        int eb;
        last_wb = got_q.size();
        eb      = got_err;
        drive(stop_n);
        if (hold) begin
            chk({name, "_wren_last"}, 64'(ramwren), 64'(1));
            chk({name, "_done_early"}, 64'(fftdone), 64'(0));
            chk({name, "_ready_hold"}, 64'(sink_ready), 64'(0));
            @(negedge clk);
            chk({name, "_done"}, 64'(fftdone), 64'(1));
        end
        repeat (3) @(negedge clk);
        exp_fc = (exp_fc + frames) % 256;
        chk({name, "_writes"}, 64'(got_q.size() - last_wb), 64'(writes));
        cmp_image(name, last_wb);
        chk({name, "_errs"}, 64'(got_err - eb), 64'(errs));
        chk({name, "_count"}, 64'(frame_count), 64'(exp_fc));
        chk({name, "_fftdone"}, 64'(fftdone), 64'(hold));
        if (hold) release_hold(name);
    endtask

    initial begin
        tbl[0] = '{2048, 2047,  -1, 0, 2048, 0, 1, 1};
        tbl[1] = '{ 101,  100,  -1, 0,  101, 1, 0, 0};
        tbl[2] = '{2049,   -1,  -1, 0, 2048, 1, 0, 0};
        tbl[3] = '{2548, 2547, 500, 0, 2548, 1, 1, 1};
        tbl[4] = '{2048, 2047,  -1, 1, 2048, 0, 1, 1};

        reset      = 1'b1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_real  = '0;
        sink_imag  = '0;
        detectdone = 1'b0;
        exp_fc     = 0;
        m_pos      = -1;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(sink_ready), 64'(0));
        chk("rst_wren", 64'(ramwren), 64'(0));
        chk("rst_addr", 64'(ramaddr), 64'(0));
        chk("rst_data", 64'(ramdata), 64'(0));
        chk("rst_done", 64'(fftdone), 64'(0));
        chk("rst_err", 64'(frame_err), 64'(0));
        chk("rst_count", 64'(frame_count), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", 64'(sink_ready), 64'(1));

        for (int i = 0; i < 5; i++) begin
            mk_frame(tbl[i].len, tbl[i].eop_at, tbl[i].sop2, tbl[i].gap);
            run_model();
            apply($sformatf("vec%0d", i), tbl[i].writes, tbl[i].errs,
                  tbl[i].frames, tbl[i].hold);
            if (i == 3) begin
                chk("restart_pre", 64'(got_q[last_wb + 499].a), 64'(499));
                chk("restart_addr0", 64'(got_q[last_wb + 500].a), 64'(0));
            end
        end

        // Reset asserted mid-frame with a beat pending.
        mk_frame(1000, -1, -1, 0);
        run_model();
        drive(stop_n);
        sink_valid = 1'b1;
        sink_real  = 14'h1234;
        sink_imag  = 14'h0abc;
        #2 reset = 1'b0;
        #1;
        chk("arst_ready", 64'(sink_ready), 64'(0));
        chk("arst_wren", 64'(ramwren), 64'(0));
        chk("arst_addr", 64'(ramaddr), 64'(0));
        chk("arst_data", 64'(ramdata), 64'(0));
        chk("arst_done", 64'(fftdone), 64'(0));
        chk("arst_err", 64'(frame_err), 64'(0));
        chk("arst_count", 64'(frame_count), 64'(0));
        @(negedge clk);
        sink_valid = 1'b0;
        reset      = 1'b1;
        exp_fc     = 0;
        m_pos      = -1;
        @(negedge clk);
        mk_frame(N, N - 1, -1, 0);
        run_model();
        apply("post_reset", N, 0, 1, 1);

        for (int t = 0; t < 4; t++) begin
            mk_rand((t == 3) ? N : 2500, t == 3);
            run_model();
            apply($sformatf("rand%0d", t), exp_q.size(), exp_err, exp_frames, exp_hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
